// File: rtl/fbindct_quant_zigzag_if.sv
// Block handshake bundle between the binDCT and the quantizer, and the serial
// beat stream from the quantizer to the entropy coder.
interface fbindct_quant_zigzag_if #(
  parameter int IN_WIDTH    = 16,
  parameter int OUT_WIDTH   = 12,
  parameter int RECIP_WIDTH = 16
);
  logic [7:0][7:0][IN_WIDTH-1:0]    coef_in;
  logic [7:0][7:0][RECIP_WIDTH-1:0] recip_in;
  logic                             coef_valid;
  logic                             coef_ready;
  logic [OUT_WIDTH-1:0]             q_out;
  logic [5:0]                       q_idx;
  logic                             q_last;
  logic                             q_sat;
  logic                             q_valid;
  logic                             q_ready;

  modport master (
    output coef_in, recip_in, coef_valid, q_ready,
    input  coef_ready, q_out, q_idx, q_last, q_sat, q_valid
  );

  modport slave (
    input  coef_in, recip_in, coef_valid, q_ready,
    output coef_ready, q_out, q_idx, q_last, q_sat, q_valid
  );
endinterface

// File: rtl/fbindct_quant_zigzag.sv
// Quantizer + zigzag serializer: captures one 8x8 block, then emits 64
// reciprocal-quantized, saturated coefficients in JPEG zigzag order.
module fbindct_quant_zigzag #(
  parameter int IN_WIDTH    = 16,
  parameter int OUT_WIDTH   = 12,
  parameter int RECIP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  fbindct_quant_zigzag_if.slave bus
);
  localparam int F  = RECIP_WIDTH;
  localparam int PW = IN_WIDTH + RECIP_WIDTH + 1;  // product + rounding carry
  localparam int MW = PW - F;                      // rounded magnitude width

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  localparam logic [MW-1:0] POS_MAX = MW'((64'd1 << (OUT_WIDTH-1)) - 64'd1);
  localparam logic [MW-1:0] NEG_MAG = MW'(64'd1 << (OUT_WIDTH-1));
  localparam logic [OUT_WIDTH-1:0] Q_MAX = OUT_WIDTH'(POS_MAX);
  localparam logic [OUT_WIDTH-1:0] Q_MIN = OUT_WIDTH'(NEG_MAG);

  // Zigzag beat -> raster position (r*8+c), beat 0 first.
  localparam logic [0:63][5:0] ZZ = {
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [0:0]                   state_q, state_d;
  logic [63:0][IN_WIDTH-1:0]    coef_buf_q, coef_buf_d;
  logic [63:0][RECIP_WIDTH-1:0] recip_buf_q, recip_buf_d;
  logic [OUT_WIDTH-1:0]         q_out_q, q_out_d;
  logic [5:0]                   q_idx_q, q_idx_d;
  logic                         q_last_q, q_last_d;
  logic                         q_sat_q, q_sat_d;
  logic                         q_valid_q, q_valid_d;

  // Flat raster views of the incoming block; [r][c] lands at r*8+c.
  logic [63:0][IN_WIDTH-1:0]    coef_flat;
  logic [63:0][RECIP_WIDTH-1:0] recip_flat;
  assign coef_flat  = bus.coef_in;
  assign recip_flat = bus.recip_in;

  logic                   accept, advance;
  logic [5:0]             nidx;
  logic [IN_WIDTH-1:0]    sel_c;
  logic [RECIP_WIDTH-1:0] sel_w;
  logic [IN_WIDTH-1:0]    mag;
  logic [PW-1:0]          prod;
  logic [MW-1:0]          p;
  logic [OUT_WIDTH-1:0]   q_calc;
  logic                   sat_calc;

  assign accept  = (state_q == S_IDLE) && bus.coef_valid;
  assign advance = (state_q == S_SCAN) && q_valid_q && bus.q_ready;
  assign nidx    = accept ? 6'd0 : q_idx_q + 6'd1;

  // Single shared quantizer: beat 0 comes straight from the input bus since
  // the buffer is only written on the accept edge itself.
  always_comb begin
    sel_c    = accept ? coef_flat[ZZ[nidx]]  : coef_buf_q[ZZ[nidx]];
    sel_w    = accept ? recip_flat[ZZ[nidx]] : recip_buf_q[ZZ[nidx]];
    mag      = sel_c[IN_WIDTH-1] ? IN_WIDTH'(-sel_c) : sel_c;
    prod     = PW'(mag) * PW'(sel_w) + (PW'(1) << (F-1));
    p        = MW'(prod >> F);
    q_calc   = '0;
    sat_calc = 1'b0;
    if (sel_c[IN_WIDTH-1]) begin
      if (p > NEG_MAG) begin
        q_calc   = Q_MIN;
        sat_calc = 1'b1;
      end else begin
        q_calc   = OUT_WIDTH'(-p);
      end
    end else begin
      if (p > POS_MAX) begin
        q_calc   = Q_MAX;
        sat_calc = 1'b1;
      end else begin
        q_calc   = OUT_WIDTH'(p);
      end
    end
  end

  // FSM, buffer capture and output register load.
  always_comb begin
    state_d     = state_q;
    coef_buf_d  = coef_buf_q;
    recip_buf_d = recip_buf_q;
    q_out_d     = q_out_q;
    q_idx_d     = q_idx_q;
    q_last_d    = q_last_q;
    q_sat_d     = q_sat_q;
    q_valid_d   = q_valid_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          coef_buf_d  = coef_flat;
          recip_buf_d = recip_flat;
          q_out_d     = q_calc;
          q_sat_d     = sat_calc;
          q_idx_d     = 6'd0;
          q_last_d    = 1'b0;
          q_valid_d   = 1'b1;
          state_d     = S_SCAN;
        end
      end
      default: begin
        if (advance) begin
          if (q_last_q) begin
            q_valid_d = 1'b0;
            state_d   = S_IDLE;
          end else begin
            q_out_d  = q_calc;
            q_sat_d  = sat_calc;
            q_idx_d  = nidx;
            q_last_d = (nidx == 6'd63);
          end
        end
      end
    endcase
  end

  // Control and output registers; reset abandons any block in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      q_out_q   <= '0;
      q_idx_q   <= '0;
      q_last_q  <= 1'b0;
      q_sat_q   <= 1'b0;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_out_q   <= q_out_d;
      q_idx_q   <= q_idx_d;
      q_last_q  <= q_last_d;
      q_sat_q   <= q_sat_d;
      q_valid_q <= q_valid_d;
    end
  end

  // Block buffer holds no meaningful state across reset.
  always_ff @(posedge clk) begin
    coef_buf_q  <= coef_buf_d;
    recip_buf_q <= recip_buf_d;
  end

  assign bus.coef_ready = (state_q == S_IDLE);
  assign bus.q_out      = q_out_q;
  assign bus.q_idx      = q_idx_q;
  assign bus.q_last     = q_last_q;
  assign bus.q_sat      = q_sat_q;
  assign bus.q_valid    = q_valid_q;
endmodule

// File: tb/tb_fbindct_quant_zigzag.sv
// Directed bench: blocks are driven in sequence, expected beats are queued at
// accept time and popped by a monitor on each output handshake.
module tb_fbindct_quant_zigzag;
  localparam int IW = 16;
  localparam int OW = 12;
  localparam int RW = 16;

  typedef struct packed {
    logic [OW-1:0] q;
    logic [5:0]    idx;
    logic          last;
    logic          sat;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fbindct_quant_zigzag_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .RECIP_WIDTH(RW)) bus ();

  fbindct_quant_zigzag #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .RECIP_WIDTH(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    zz[64];
  int    blk_c[64];
  int    blk_w[64];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Zigzag order derived by walking anti-diagonals, alternating direction.
  task automatic build_zz();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz[k] = r * 8 + (s - r); k++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz[k] = r * 8 + (s - r); k++; end
      end
    end
  endtask

  function automatic beat_t model(input int c, input int w, input int k);
    longint m, p, q;
    beat_t  b;
    m = (c < 0) ? -longint'(c) : longint'(c);
    p = (m * longint'(w) + (longint'(1) <<< (RW - 1))) >>> RW;
    q = (c < 0) ? -p : p;
    b.sat = 1'b0;
    if (q > (longint'(1) <<< (OW - 1)) - 1) begin q = (longint'(1) <<< (OW - 1)) - 1; b.sat = 1'b1; end
    if (q < -(longint'(1) <<< (OW - 1)))    begin q = -(longint'(1) <<< (OW - 1));     b.sat = 1'b1; end
    b.q    = q[OW-1:0];
    b.idx  = k[5:0];
    b.last = (k == 63);
    return b;
  endfunction

  task automatic load_block();
    for (int i = 0; i < 64; i++) begin
      bus.coef_in[i / 8][i % 8]  = blk_c[i][IW-1:0];
      bus.recip_in[i / 8][i % 8] = blk_w[i][RW-1:0];
    end
  endtask

  task automatic push_expected();
    for (int k = 0; k < 64; k++) sb.push_back(model(blk_c[zz[k]], blk_w[zz[k]], k));
  endtask

  task automatic set_order_block();
    for (int i = 0; i < 64; i++) begin blk_c[i] = i; blk_w[i] = 65535; end
  endtask

  task automatic send_block(input string tag);
    int n = 0;
    @(negedge clk);
    while (!bus.coef_ready && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_ready"}, 64'(bus.coef_ready), 64'd1);
    load_block();
    bus.coef_valid = 1'b1;
    push_expected();
    @(posedge clk);
    #1 bus.coef_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((bus.q_valid || sb.size() != 0) && n < 3000) begin @(negedge clk); n++; end
    chk({tag, "_drained"}, 64'(sb.size()), 64'd0);
    chk({tag, "_valid_low"}, 64'(bus.q_valid), 64'd0);
  endtask

  // Handshake monitor: scoreboard compare, stall stability, busy coef_ready.
  logic        stall_prev = 1'b0;
  logic [63:0] held;
  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        chk("stall_hold", {39'd0, bus.q_valid, bus.q_sat, bus.q_last, bus.q_idx, bus.q_out}, held);
      if (bus.q_valid) chk("coef_ready_busy", 64'(bus.coef_ready), 64'd0);
      if (bus.q_valid && bus.q_ready) begin
        chk("beat_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("q_out",  64'(bus.q_out),  64'(e.q));
          chk("q_idx",  64'(bus.q_idx),  64'(e.idx));
          chk("q_last", 64'(bus.q_last), 64'(e.last));
          chk("q_sat",  64'(bus.q_sat),  64'(e.sat));
        end
      end
      stall_prev = bus.q_valid && !bus.q_ready;
      held = {39'd0, bus.q_valid, bus.q_sat, bus.q_last, bus.q_idx, bus.q_out};
    end
  end

  initial begin
    int n;
    build_zz();
    bus.coef_valid = 1'b0;
    bus.q_ready    = 1'b1;
    for (int i = 0; i < 64; i++) begin blk_c[i] = 0; blk_w[i] = 0; end
    load_block();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_coef_ready", 64'(bus.coef_ready), 64'd1);
    chk("rst_q_valid",    64'(bus.q_valid),    64'd0);
    chk("rst_q_out",      64'(bus.q_out),      64'd0);
    chk("rst_q_idx",      64'(bus.q_idx),      64'd0);
    chk("rst_q_last",     64'(bus.q_last),     64'd0);
    chk("rst_q_sat",      64'(bus.q_sat),      64'd0);
    rst = 1'b1;

    // DC-only block with zero stalls; order block held on coef_valid the
    // whole time, so it must be ignored during SCAN and taken one cycle
    // after the beat-63 handshake.
    for (int i = 0; i < 64; i++) begin blk_c[i] = 0; blk_w[i] = 4096; end
    blk_c[0] = 100;
    @(negedge clk);
    chk("dc_ready", 64'(bus.coef_ready), 64'd1);
    load_block();
    bus.coef_valid = 1'b1;
    push_expected();
    @(posedge clk);
    #1;
    set_order_block();
    load_block();
    push_expected();
    repeat (63) @(posedge clk);
    @(negedge clk);
    chk("t63_last",       64'(bus.q_last),     64'd1);
    chk("t63_idx",        64'(bus.q_idx),      64'd63);
    chk("t63_coef_ready", 64'(bus.coef_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t64_coef_ready", 64'(bus.coef_ready), 64'd1);
    chk("t64_q_valid",    64'(bus.q_valid),    64'd0);
    @(posedge clk);
    #1 bus.coef_valid = 1'b0;
    @(negedge clk);
    chk("t65_q_valid",    64'(bus.q_valid),    64'd1);
    chk("t65_q_idx",      64'(bus.q_idx),      64'd0);
    chk("t65_coef_ready", 64'(bus.coef_ready), 64'd0);
    wait_idle("order");

    // Rounding, sign, saturation, zero and unity reciprocals, random fill
    for (int i = 0; i < 64; i++) begin
      blk_c[i] = int'($urandom_range(0, 65535)) - 32768;
      blk_w[i] = int'($urandom_range(0, 65535));
    end
    blk_c[0] = 24;     blk_w[0] = 4096;
    blk_c[1] = -24;    blk_w[1] = 4096;
    blk_c[2] = -23;    blk_w[2] = 4096;
    blk_c[3] = 7;      blk_w[3] = 4096;
    blk_c[4] = -8;     blk_w[4] = 4096;
    blk_c[8] = 4000;   blk_w[8] = 65535;
    blk_c[9] = -4000;  blk_w[9] = 65535;
    blk_c[10] = 2047;  blk_w[10] = 65535;
    blk_c[16] = -32768; blk_w[16] = 65535;
    blk_c[17] = 5000;  blk_w[17] = 0;
    blk_c[18] = -2048; blk_w[18] = 65535;
    send_block("arith");
    wait_idle("arith");

    // Backpressure: stall 5 cycles at beat 10, then random ready
    set_order_block();
    send_block("bp");
    n = 0;
    while (!(bus.q_valid && bus.q_idx == 6'd10) && n < 200) begin @(posedge clk); #1; n++; end
    chk("bp_reach10", 64'(bus.q_idx), 64'd10);
    bus.q_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n = 0;
    while (bus.q_valid && n < 2000) begin
      bus.q_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      n++;
    end
    bus.q_ready = 1'b1;
    wait_idle("bp");
    chk("bp_coef_ready_after", 64'(bus.coef_ready), 64'd1);

    // Asynchronous reset mid-block, then a clean block from index 0
    set_order_block();
    send_block("rst_a");
    n = 0;
    while (!(bus.q_valid && bus.q_idx == 6'd30) && n < 200) begin @(posedge clk); #1; n++; end
    chk("rst_reach30", 64'(bus.q_idx), 64'd30);
    rst = 1'b0;
    #1;
    chk("async_q_valid",    64'(bus.q_valid),    64'd0);
    chk("async_coef_ready", 64'(bus.coef_ready), 64'd1);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    send_block("rst_b");
    @(negedge clk);
    chk("rst_b_first_idx", 64'(bus.q_idx), 64'd0);
    wait_idle("rst_b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
